// File: rtl/branch_predict_unit.sv
// Branch resolution in EX plus a fetch-side predictor: a BHT of 2-bit saturating
// counters and a tagged, direct-mapped BTB, with a saturating mispredict counter.
module branch_predict_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int BTB_IDX_W = 4,
    parameter int TAG_W     = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic [XLEN-1:0]  if_pred_target,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [4:0]       ex_brop,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             ex_taken,
    output logic             ex_mispredict,
    output logic [XLEN-1:0]  ex_redirect_pc,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam int BHT_N = 2 ** BHT_IDX_W;
    localparam int BTB_N = 2 ** BTB_IDX_W;

    logic [1:0]       bht_q        [BHT_N];
    logic [1:0]       bht_d        [BHT_N];
    logic             btb_valid_q  [BTB_N];
    logic             btb_valid_d  [BTB_N];
    logic [TAG_W-1:0] btb_tag_q    [BTB_N];
    logic [TAG_W-1:0] btb_tag_d    [BTB_N];
    logic [XLEN-1:0]  btb_target_q [BTB_N];
    logic [XLEN-1:0]  btb_target_d [BTB_N];
    logic             btb_jump_q   [BTB_N];
    logic             btb_jump_d   [BTB_N];
    logic [CNT_W-1:0] mispredict_cnt_q;
    logic [CNT_W-1:0] mispredict_cnt_d;

    logic [BHT_IDX_W-1:0] if_bht_idx;
    logic [BTB_IDX_W-1:0] if_btb_idx;
    logic [TAG_W-1:0]     if_tag;
    logic [BHT_IDX_W-1:0] ex_bht_idx;
    logic [BTB_IDX_W-1:0] ex_btb_idx;
    logic [TAG_W-1:0]     ex_tag;
    logic                 ex_act;
    logic                 is_jump;
    logic                 is_branch;
    logic                 ctl;
    logic                 unused_if_pc_bits;

    assign if_bht_idx = if_pc[BHT_IDX_W+1:2];
    assign if_btb_idx = if_pc[BTB_IDX_W+1:2];
    assign if_tag     = if_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
    assign ex_bht_idx = ex_pc[BHT_IDX_W+1:2];
    assign ex_btb_idx = ex_pc[BTB_IDX_W+1:2];
    assign ex_tag     = ex_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
    assign ex_act     = rst_n && ex_valid;
    assign mispredict_cnt = mispredict_cnt_q;
    assign unused_if_pc_bits = ^{if_pc[1:0], if_pc[XLEN-1:BTB_IDX_W+TAG_W+2]};

    // Lookup reads registered state only, so a same-cycle update is not visible here.
    always_comb begin
        if_pred_taken  = 1'b0;
        if_pred_target = '0;
        if (rst_n && btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_tag) &&
            (btb_jump_q[if_btb_idx] || bht_q[if_bht_idx][1])) begin
            if_pred_taken  = 1'b1;
            if_pred_target = btb_target_q[if_btb_idx];
        end
    end

    always_comb begin
        ex_taken  = 1'b0;
        is_branch = 1'b0;
        is_jump   = ex_act && ex_brop[4];
        if (is_jump) begin
            ex_taken = 1'b1;
        end else if (ex_act && ex_brop[3]) begin
            is_branch = 1'b1;
            case (ex_brop[2:0])
                3'b000:  ex_taken = (ex_rs1 == ex_rs2);
                3'b001:  ex_taken = (ex_rs1 != ex_rs2);
                3'b100:  ex_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
                3'b101:  ex_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
                3'b110:  ex_taken = (ex_rs1 <  ex_rs2);
                3'b111:  ex_taken = (ex_rs1 >= ex_rs2);
                default: is_branch = 1'b0;
            endcase
        end
        ctl            = is_jump || is_branch;
        ex_mispredict  = ctl && ((ex_taken != ex_pred_taken) ||
                                 (ex_taken && (ex_pred_target != ex_target)));
        ex_redirect_pc = '0;
        if (ex_act) begin
            ex_redirect_pc = ex_taken ? ex_target : (ex_pc + XLEN'(4));
        end
    end

    always_comb begin
        bht_d            = bht_q;
        btb_valid_d      = btb_valid_q;
        btb_tag_d        = btb_tag_q;
        btb_target_d     = btb_target_q;
        btb_jump_d       = btb_jump_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (is_jump) begin
            bht_d[ex_bht_idx] = 2'b11;
        end else if (is_branch) begin
            if (ex_taken && (bht_q[ex_bht_idx] != 2'b11)) begin
                bht_d[ex_bht_idx] = bht_q[ex_bht_idx] + 2'b01;
            end else if (!ex_taken && (bht_q[ex_bht_idx] != 2'b00)) begin
                bht_d[ex_bht_idx] = bht_q[ex_bht_idx] - 2'b01;
            end
        end
        // Not-taken branches leave the BTB alone so a learned target survives.
        if (ctl && ex_taken) begin
            btb_valid_d[ex_btb_idx]  = 1'b1;
            btb_tag_d[ex_btb_idx]    = ex_tag;
            btb_target_d[ex_btb_idx] = ex_target;
            btb_jump_d[ex_btb_idx]   = ex_brop[4];
        end
        if (ex_mispredict && (mispredict_cnt_q != {CNT_W{1'b1}})) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= 2'b01;
            end
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
                btb_jump_q[i]   <= 1'b0;
            end
            mispredict_cnt_q <= '0;
        end else begin
            bht_q            <= bht_d;
            btb_valid_q      <= btb_valid_d;
            btb_tag_q        <= btb_tag_d;
            btb_target_q     <= btb_target_d;
            btb_jump_q       <= btb_jump_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed scoreboard bench: each cycle's expected outputs are queued by the stimulus
// and checked by an independent monitor on the falling edge.
module tb_branch_predict_unit;
    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_JUMP = 5'b10000;
    localparam logic [4:0] OP_JBNE = 5'b11001;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_BLT  = 5'b01100;
    localparam logic [4:0] OP_BGE  = 5'b01101;
    localparam logic [4:0] OP_BLTU = 5'b01110;
    localparam logic [4:0] OP_BGEU = 5'b01111;
    localparam logic [4:0] OP_BAD  = 5'b01010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_rs1 = '0;
    logic [31:0] ex_rs2 = '0;
    logic [4:0]  ex_brop = '0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        ex_taken;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc;
    logic [1:0]  mispredict_cnt;

    typedef struct {
        logic        ipt;
        logic [31:0] iptg;
        logic        tk;
        logic        mp;
        logic [31:0] rd;
        logic [1:0]  cnt;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;
    logic [1:0] exp_cnt = 2'd0;

    branch_predict_unit #(.XLEN(32), .BHT_IDX_W(6), .BTB_IDX_W(4), .TAG_W(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_brop(ex_brop), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_taken(ex_taken), .ex_mispredict(ex_mispredict),
        .ex_redirect_pc(ex_redirect_pc), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                chk(nm, "if_pred_taken", {31'd0, if_pred_taken}, {31'd0, e.ipt});
                chk(nm, "if_pred_target", if_pred_target, e.iptg);
                chk(nm, "ex_taken", {31'd0, ex_taken}, {31'd0, e.tk});
                chk(nm, "ex_mispredict", {31'd0, ex_mispredict}, {31'd0, e.mp});
                chk(nm, "ex_redirect_pc", ex_redirect_pc, e.rd);
                chk(nm, "mispredict_cnt", {30'd0, mispredict_cnt}, {30'd0, e.cnt});
                $display("txn %s: pred=%b/%h taken=%b misp=%b redirect=%h cnt=%0d",
                         nm, if_pred_taken, if_pred_target, ex_taken, ex_mispredict,
                         ex_redirect_pc, mispredict_cnt);
            end
        end
    end

    // Drives one cycle of stimulus; expected mispredict count tracks the hand-given flags.
    task automatic vec(input string nm, input logic rstn, input logic [31:0] ipc,
                       input logic v, input logic [4:0] op, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptg,
                       input logic e_ipt, input logic [31:0] e_iptg,
                       input logic e_tk, input logic e_mp, input logic [31:0] e_rd);
        exp_t e;
        rst_n = rstn; if_pc = ipc; ex_valid = v; ex_brop = op; ex_pc = pc;
        ex_rs1 = a; ex_rs2 = b; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
        e.ipt = e_ipt; e.iptg = e_iptg; e.tk = e_tk; e.mp = e_mp; e.rd = e_rd;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        if (!rstn) exp_cnt = 2'd0;
        else if (e_mp && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        #1;
        //   name            rst ifpc   v op       pc     rs1   rs2  tgt    pt ptgt    ipt iptg  tk mp redirect
        vec("rst_force",     0, 'h100, 1, OP_JUMP, 'h40, 0, 0, 'h500, 0, 0,         0, 0,    0, 0, 0);
        vec("rst_idle",      0, 'h100, 0, OP_NONE, 0, 0, 0, 0, 0, 0,                0, 0,    0, 0, 0);
        vec("beq_cold",      1, 'h40, 1, OP_BEQ, 'h40, 10, 10, 'h80, 0, 0,          0, 0,    1, 1, 'h80);
        vec("beq_learned",   1, 'h40, 0, OP_NONE, 0, 0, 0, 0, 0, 0,                 1, 'h80, 0, 0, 0);
        vec("tag_miss",      1, 'h80, 0, OP_NONE, 0, 0, 0, 0, 0, 0,                 0, 0,    0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            vec($sformatf("bne_t%0d", i), 1, 'h40, 1, OP_BNE, 'h40, 1, 2, 'h80, 1, 'h80,
                1, 'h80, 1, 0, 'h80);
        end
        vec("bne_nt1",       1, 'h40, 1, OP_BNE, 'h40, 5, 5, 'h80, 1, 'h80,         1, 'h80, 0, 1, 'h44);
        vec("bne_nt2",       1, 'h40, 1, OP_BNE, 'h40, 5, 5, 'h80, 1, 'h80,         1, 'h80, 0, 1, 'h44);
        vec("lookup_nt",     1, 'h40, 0, OP_NONE, 0, 0, 0, 0, 0, 0,                 0, 0,    0, 0, 0);
        vec("blt_signed",    1, 'h100, 1, OP_BLT, 'h148, 32'hFFFF_FFFF, 1, 'h180, 0, 0,  0, 0, 1, 1, 'h180);
        vec("bltu_unsigned", 1, 'h100, 1, OP_BLTU, 'h148, 32'hFFFF_FFFF, 1, 'h180, 0, 0, 0, 0, 0, 0, 'h14C);
        vec("bgeu_unsigned", 1, 'h100, 1, OP_BGEU, 'h148, 32'hFFFF_FFFF, 1, 'h180, 1, 'h180, 0, 0, 1, 0, 'h180);
        vec("bge_signed",    1, 'h100, 1, OP_BGE, 'h148, 32'hFFFF_FFFF, 1, 'h180, 0, 0,  0, 0, 0, 0, 'h14C);
        vec("jalr_cold",     1, 'h200, 1, OP_JUMP, 'h200, 0, 0, 'h300, 0, 0,        0, 0,     1, 1, 'h300);
        vec("jalr_learned",  1, 'h200, 0, OP_NONE, 0, 0, 0, 0, 0, 0,                1, 'h300, 0, 0, 0);
        vec("jalr_change",   1, 'h200, 1, OP_JUMP, 'h200, 0, 0, 'h400, 1, 'h300,    1, 'h300, 1, 1, 'h400);
        vec("jalr_relearn",  1, 'h200, 0, OP_NONE, 0, 0, 0, 0, 0, 0,                1, 'h400, 0, 0, 0);
        vec("bad_funct3",    1, 'h200, 1, OP_BAD, 'h200, 7, 7, 'h600, 1, 'h400,     1, 'h400, 0, 0, 'h204);
        vec("after_bad",     1, 'h200, 0, OP_NONE, 0, 0, 0, 0, 0, 0,                1, 'h400, 0, 0, 0);
        vec("jump_wins",     1, 'h200, 1, OP_JBNE, 'h200, 3, 3, 'h400, 1, 'h400,    1, 'h400, 1, 0, 'h400);
        vec("ex_invalid",    1, 'h100, 0, OP_JUMP, 'h200, 0, 0, 'h700, 0, 0,        0, 0,     0, 0, 0);
        vec("pc_wrap",       1, 'h100, 1, OP_NONE, 32'hFFFF_FFFC, 0, 0, 'h10, 1, 'h10, 0, 0,  0, 0, 0);
        vec("rst_mid",       0, 'h200, 1, OP_JUMP, 'h200, 0, 0, 'h800, 0, 0,        0, 0,     0, 0, 0);
        vec("post_rst",      1, 'h200, 0, OP_NONE, 0, 0, 0, 0, 0, 0,                0, 0,     0, 0, 0);
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
